// File: rtl/bus_pkg.sv
// bus_pkg: shared bus geometry and the source index map for the datapath bus.
// Contents: N_SRC/SEL_W constants, src_idx_t, SRC_* indices (24..31 reserved).
package bus_pkg;
    localparam int N_SRC = 32;
    localparam int SEL_W = 5;
    typedef logic [SEL_W-1:0] src_idx_t;
    localparam src_idx_t SRC_R0     = 5'd0;
    localparam src_idx_t SRC_R1     = 5'd1;
    localparam src_idx_t SRC_R2     = 5'd2;
    localparam src_idx_t SRC_R3     = 5'd3;
    localparam src_idx_t SRC_R4     = 5'd4;
    localparam src_idx_t SRC_R5     = 5'd5;
    localparam src_idx_t SRC_R6     = 5'd6;
    localparam src_idx_t SRC_R7     = 5'd7;
    localparam src_idx_t SRC_R8     = 5'd8;
    localparam src_idx_t SRC_R9     = 5'd9;
    localparam src_idx_t SRC_R10    = 5'd10;
    localparam src_idx_t SRC_R11    = 5'd11;
    localparam src_idx_t SRC_R12    = 5'd12;
    localparam src_idx_t SRC_R13    = 5'd13;
    localparam src_idx_t SRC_R14    = 5'd14;
    localparam src_idx_t SRC_R15    = 5'd15;
    localparam src_idx_t SRC_HI     = 5'd16;
    localparam src_idx_t SRC_LO     = 5'd17;
    localparam src_idx_t SRC_ZHI    = 5'd18;
    localparam src_idx_t SRC_ZLO    = 5'd19;
    localparam src_idx_t SRC_PC     = 5'd20;
    localparam src_idx_t SRC_MDR    = 5'd21;
    localparam src_idx_t SRC_INPORT = 5'd22;
    localparam src_idx_t SRC_CSIGN  = 5'd23;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational pick of the first set request at or after ptr, wrapping.
// Ports: req_i requests, ptr_i search start, idx_o winner index, any_o some request set.
module rr_priority_pick import bus_pkg::*; #(
    parameter int N = N_SRC,
    parameter int W = SEL_W
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    logic [N-1:0] rot;
    logic [W-1:0] off;
    always_comb begin
        // Rotate so ptr lands at bit 0, find lowest set bit, then add ptr back (wraps mod N).
        rot = N'({req_i, req_i} >> ptr_i);
        off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = W'(i);
        idx_o = off + ptr_i;
        any_o = |req_i;
    end
endmodule

// File: rtl/bus_source_encoder.sv
// bus_source_encoder: one-hot bus source requests to registered mux select with arbitration, lock and conflict count.
// Ports: clock, clear (sync active-high), req, lock in; sel, grant, valid, conflict, conflict_cnt out (all registered).
// Build option: BUS_ENC_RR_EN selects round-robin; otherwise fixed priority (lowest index wins).
module bus_source_encoder import bus_pkg::*; #(
    parameter int N_SRC = bus_pkg::N_SRC,
    parameter int SEL_W = bus_pkg::SEL_W,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [N_SRC-1:0] req,
    input  logic             lock,
    output logic [SEL_W-1:0] sel,
    output logic [N_SRC-1:0] grant,
    output logic             valid,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);
    logic [SEL_W-1:0] sel_q, sel_d, win, ptr_q;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic             valid_q, valid_d, conflict_q, conflict_d, any, hold;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    rr_priority_pick #(.N(N_SRC), .W(SEL_W)) u_pick (
        .req_i(req),
        .ptr_i(ptr_q),
        .idx_o(win),
        .any_o(any)
    );

    // Lock only holds a grant that already exists and whose holder is still requesting.
    assign hold = lock && valid_q && req[sel_q];

    always_comb begin
        grant_d    = hold ? grant_q : (any ? N_SRC'(1) << win : '0);
        sel_d      = (hold || !any) ? sel_q : win;
        valid_d    = hold || any;
        conflict_d = (req & (req - N_SRC'(1))) != '0;
        cnt_d      = (conflict_d && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            sel_q      <= '0;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef BUS_ENC_RR_EN
    logic [SEL_W-1:0] ptr_d;
    assign ptr_d = (any && !hold) ? win + SEL_W'(1) : ptr_q;
    always_ff @(posedge clock) begin
        if (clear) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
`else
    assign ptr_q = '0;
`endif

    assign sel          = sel_q;
    assign grant        = grant_q;
    assign valid        = valid_q;
    assign conflict     = conflict_q;
    assign conflict_cnt = cnt_q;
endmodule
